// File: rtl/hello_char_src.sv
// Streams "Hello World\n" over valid/ready with a programmable gap and pass count.
// Define HELLO_CHECKSUM_EN to append the XOR checksum byte 8'h2A at index 12.
module hello_char_src #(
    parameter int GAP_CYCLES = 0,
    parameter int REPEAT     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] char_idx,
    output logic       busy,
    output logic       done
);

`ifdef HELLO_CHECKSUM_EN
    localparam int MSG_LEN = 13;
`else
    localparam int MSG_LEN = 12;
`endif

    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int PW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PW-1:0] PASS_LAST = PW'((REPEAT > 0) ? REPEAT - 1 : 0);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [3:0]    char_idx_q, char_idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [PW-1:0] pass_q, pass_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [3:0]    nxt_idx;

    function automatic logic [7:0] rom(input logic [3:0] i);
        logic [7:0] b;
        case (i)
            4'd0:    b = 8'h48;
            4'd1:    b = 8'h65;
            4'd2:    b = 8'h6C;
            4'd3:    b = 8'h6C;
            4'd4:    b = 8'h6F;
            4'd5:    b = 8'h20;
            4'd6:    b = 8'h57;
            4'd7:    b = 8'h6F;
            4'd8:    b = 8'h72;
            4'd9:    b = 8'h6C;
            4'd10:   b = 8'h64;
            4'd11:   b = 8'h0A;
`ifdef HELLO_CHECKSUM_EN
            4'd12:   b = 8'h2A;
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        char_idx_d  = char_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        gap_d       = gap_q;
        nxt_idx     = 4'd0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SEND;
                    out_valid_d = 1'b1;
                    out_data_d  = rom(4'd0);
                    char_idx_d  = 4'd0;
                    busy_d      = 1'b1;
                    pass_d      = '0;
                    gap_d       = '0;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (char_idx_q == LAST_IDX && pass_q == PASS_LAST) begin
                        state_d     = DONE;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        if (char_idx_q == LAST_IDX) begin
                            nxt_idx = 4'd0;
                            pass_d  = pass_q + 1'b1;
                        end else begin
                            nxt_idx = char_idx_q + 4'd1;
                        end
                        char_idx_d = nxt_idx;
                        out_data_d = rom(nxt_idx);
                        // Next byte is staged now; GAP only withholds valid.
                        if (GAP_CYCLES > 0) begin
                            state_d     = GAP;
                            out_valid_d = 1'b0;
                            gap_d       = '0;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d     = SEND;
                    out_valid_d = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            char_idx_q  <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            char_idx_q  <= char_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            gap_q       <= gap_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign char_idx  = char_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
